fp_stage_pipe: RTL and testbench

//  Parametrised function-processing stage of the data-driven pipeline; successor to the fixed 16-bit FP stage.

---
 rtl/fp_stage_pipe_if.sv | 25 ++
 rtl/fp_stage_pipe.sv | 154 +++++++++++++++
 tb/tb_fp_stage_pipe.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/fp_stage_pipe_if.sv
// Upstream (packet/Send/Ack/DEL) and downstream (FIFO head, store port) signals of the FP stage.
// slave is the stage's view; master is the view of whatever drives the stage.
interface fp_stage_pipe_if #(
  parameter int DATA_W = 16,
  parameter int HDR_W  = 22
);
  localparam int IN_W  = HDR_W + 8 + 2*DATA_W;
  localparam int OUT_W = HDR_W + 8 + DATA_W;

  logic [IN_W-1:0]   PACKET_IN;
  logic              Send_in;
  logic              Ack_out;
  logic              DEL;
  logic [OUT_W-1:0]  PACKET_OUT;
  logic              Send_out;
  logic              Ack_in;
  logic              LOAD_FLG;
  logic              WRITE_EN;
  logic [DATA_W-1:0] WRITE_DATA;

  modport master (output PACKET_IN, Send_in, DEL, Ack_in,
                  input  Ack_out, PACKET_OUT, Send_out, LOAD_FLG, WRITE_EN, WRITE_DATA);
  modport slave  (input  PACKET_IN, Send_in, DEL, Ack_in,
                  output Ack_out, PACKET_OUT, Send_out, LOAD_FLG, WRITE_EN, WRITE_DATA);
endinterface

// File: rtl/fp_stage_pipe.sv
// Function-processing stage: latch a packet, run its opcode (shift-add MUL over DATA_W cycles),
// and queue results in a DEPTH-entry FIFO drained under Send/Ack.
module fp_stage_pipe #(
  parameter int DATA_W = 16,
  parameter int HDR_W  = 22,
  parameter int DEPTH  = 4
) (
  input  logic           CP,
  input  logic           MR,
  fp_stage_pipe_if.slave bus
);
  localparam int ENT_W = HDR_W + 8 + DATA_W + 1;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DATA_W + 1);

  localparam logic [5:0] OP_ADD = 6'd1, OP_ADDC = 6'd2, OP_SUB = 6'd3, OP_AND = 6'd4,
                         OP_OR  = 6'd5, OP_XOR  = 6'd6, OP_SHL = 6'd7, OP_SHR = 6'd8,
                         OP_MUL = 6'd9, OP_STORE = 6'd10, OP_LOAD = 6'd11;

  typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;

  state_t            r_state;
  logic [HDR_W-1:0]  r_hdr;
  logic [5:0]        r_opc;
  logic [1:0]        r_tag;
  logic [DATA_W-1:0] r_dl, r_dr;
  logic              r_c;
  logic [DATA_W-1:0] r_acc, r_mcand, r_mplr;
  logic [CW-1:0]     r_step;
  logic              r_wen;
  logic [DATA_W-1:0] r_wdata;
  logic [ENT_W-1:0]  r_mem [DEPTH];
  logic [PW-1:0]     r_wr, r_rd;
  logic [PW:0]       r_cnt;

  logic [HDR_W-1:0]  w_in_hdr;
  logic [5:0]        w_in_opc;
  logic [1:0]        w_in_tag;
  logic [DATA_W-1:0] w_in_l, w_in_r;
  logic              w_full, w_empty, w_ack, w_load, w_pop, w_exec, w_mul_done, w_push;
  logic [DATA_W-1:0] w_res;
  logic              w_c_nxt;
  logic [ENT_W-1:0]  w_entry;

  assign {w_in_hdr, w_in_opc, w_in_tag, w_in_l, w_in_r} = bus.PACKET_IN;

  assign w_full     = (r_cnt == (PW+1)'(DEPTH));
  assign w_empty    = (r_cnt == '0);
  assign w_ack      = (r_state == IDLE) || (r_state == EXEC && r_opc != OP_MUL && !w_full);
  assign w_load     = bus.Send_in && w_ack && !bus.DEL;
  assign w_pop      = !w_empty && bus.Ack_in;
  // A single-cycle op retires only when the FIFO has room, even if it is a STORE.
  assign w_exec     = (r_state == EXEC) && (r_opc != OP_MUL) && !w_full;
  assign w_mul_done = (r_state == MUL) && (r_step == CW'(DATA_W)) && !w_full;
  assign w_push     = (w_exec && r_opc != OP_STORE) || w_mul_done;

  always_comb begin
    w_res   = r_dl;
    w_c_nxt = r_c;
    case (r_opc)
      OP_ADD:  {w_c_nxt, w_res} = {1'b0, r_dl} + {1'b0, r_dr};
      OP_ADDC: {w_c_nxt, w_res} = {1'b0, r_dl} + {1'b0, r_dr} + {{DATA_W{1'b0}}, r_c};
      OP_SUB:  {w_c_nxt, w_res} = {1'b0, r_dl} - {1'b0, r_dr};
      OP_AND:  w_res = r_dl & r_dr;
      OP_OR:   w_res = r_dl | r_dr;
      OP_XOR:  w_res = r_dl ^ r_dr;
      OP_SHL:  w_res = r_dl << r_dr[3:0];
      OP_SHR:  w_res = r_dl >> r_dr[3:0];
      OP_MUL:  w_res = r_acc;
      default: ;
    endcase
  end

  assign w_entry = {r_hdr, r_opc, r_tag, w_res, (r_opc == OP_LOAD)};

  always_ff @(posedge CP or posedge MR) begin
    if (MR) begin
      r_state <= IDLE;
      r_hdr   <= '0;
      r_opc   <= '0;
      r_tag   <= '0;
      r_dl    <= '0;
      r_dr    <= '0;
      r_c     <= 1'b0;
      r_acc   <= '0;
      r_mcand <= '0;
      r_mplr  <= '0;
      r_step  <= '0;
      r_wen   <= 1'b0;
      r_wdata <= '0;
    end else begin
      r_wen <= 1'b0;
      if (w_load) {r_hdr, r_opc, r_tag, r_dl, r_dr} <= {w_in_hdr, w_in_opc, w_in_tag, w_in_l, w_in_r};
      if (w_exec) r_c <= w_c_nxt;
      if (w_exec && r_opc == OP_STORE) begin
        r_wen   <= 1'b1;
        r_wdata <= r_dr;
      end
      case (r_state)
        IDLE: if (w_load) r_state <= EXEC;
        EXEC: begin
          if (r_opc == OP_MUL) begin
            r_state <= MUL;
            r_acc   <= '0;
            r_mcand <= r_dl;
            r_mplr  <= r_dr;
            r_step  <= '0;
          end else if (!w_full) begin
            r_state <= w_load ? EXEC : IDLE;
          end
        end
        MUL: begin
          // One multiplier bit per cycle; the product then waits here for FIFO room.
          if (r_step != CW'(DATA_W)) begin
            r_acc   <= r_acc + (r_mplr[0] ? r_mcand : '0);
            r_mcand <= r_mcand << 1;
            r_mplr  <= r_mplr >> 1;
            r_step  <= r_step + 1'b1;
          end else if (!w_full) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CP or posedge MR) begin
    if (MR) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CP) begin
    if (w_push) r_mem[r_wr] <= w_entry;
  end

  assign bus.Ack_out    = w_ack;
  assign bus.Send_out   = !w_empty;
  assign bus.PACKET_OUT = w_empty ? '0 : r_mem[r_rd][ENT_W-1:1];
  assign bus.LOAD_FLG   = !w_empty && r_mem[r_rd][0];
  assign bus.WRITE_EN   = r_wen;
  assign bus.WRITE_DATA = r_wdata;
endmodule

// File: tb/tb_fp_stage_pipe.sv
// Scoreboard bench for fp_stage_pipe: directed corner cases plus random packets
// against an arithmetic reference model.
module tb_fp_stage_pipe;
  localparam int DATA_W = 16;
  localparam int HDR_W  = 22;
  localparam int DEPTH  = 4;
  localparam int OUT_W  = HDR_W + 8 + DATA_W;

  localparam logic [5:0] OP_ADD = 6'd1, OP_ADDC = 6'd2, OP_SUB = 6'd3, OP_AND = 6'd4,
                         OP_OR  = 6'd5, OP_XOR  = 6'd6, OP_SHL = 6'd7, OP_SHR = 6'd8,
                         OP_MUL = 6'd9, OP_STORE = 6'd10, OP_LOAD = 6'd11;

  logic CP, MR;
  fp_stage_pipe_if #(.DATA_W(DATA_W), .HDR_W(HDR_W)) bus ();
  fp_stage_pipe #(.DATA_W(DATA_W), .HDR_W(HDR_W), .DEPTH(DEPTH)) dut (.CP(CP), .MR(MR), .bus(bus));

  initial CP = 1'b0;
  always #5 CP = ~CP;

  int n_tests = 0;
  int n_fail  = 0;
  logic [OUT_W:0]    exp_q [$];
  logic [DATA_W-1:0] st_q  [$];
  logic              m_c;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_evt(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s actual=no-event required=event at %0t", nm, $time);
  endtask

  // Reference model: evaluated once per executed packet, in acceptance order.
  task automatic model(input logic [HDR_W-1:0] h, input logic [5:0] op, input logic [1:0] t,
                       input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
    longint m = longint'(1) << DATA_W;
    longint s;
    logic [DATA_W-1:0] res = l;
    logic ld = 1'b0;
    case (op)
      OP_ADD:   begin s = longint'(l) + longint'(r); m_c = (s >= m); res = DATA_W'(s % m); end
      OP_ADDC:  begin s = longint'(l) + longint'(r) + longint'(m_c); m_c = (s >= m); res = DATA_W'(s % m); end
      OP_SUB:   begin m_c = (l < r); res = DATA_W'((longint'(l) - longint'(r) + m) % m); end
      OP_AND:   res = l & r;
      OP_OR:    res = l | r;
      OP_XOR:   res = l ^ r;
      OP_SHL:   res = DATA_W'((longint'(l) << r[3:0]) % m);
      OP_SHR:   res = DATA_W'(longint'(l) >> r[3:0]);
      OP_MUL:   res = DATA_W'((longint'(l) * longint'(r)) % m);
      OP_STORE: begin st_q.push_back(r); return; end
      OP_LOAD:  ld = 1'b1;
      default:  ;
    endcase
    exp_q.push_back({h, op, t, res, ld});
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [HDR_W-1:0] h, input logic [5:0] op, input logic [1:0] t,
                      input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r,
                      input logic del, input logic rnd);
    bus.PACKET_IN = {h, op, t, l, r};
    bus.DEL       = del;
    bus.Send_in   = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge CP);
      if (bus.Ack_out) begin
        @(posedge CP);
        #1;
        if (!del) model(h, op, t, l, r);
        bus.Send_in = 1'b0;
        bus.DEL     = 1'b0;
        return;
      end
      @(posedge CP);
      #1;
      if (rnd) bus.Ack_in = ($urandom_range(0, 3) != 0);
    end
    fail_evt("send_timeout");
    bus.Send_in = 1'b0;
    bus.DEL     = 1'b0;
  endtask

  task automatic drain(input int budget);
    bus.Ack_in = 1'b1;
    for (int k = 0; k < budget; k++) begin
      @(posedge CP);
      #2;
      if (exp_q.size() == 0 && st_q.size() == 0 && !bus.Send_out) break;
    end
    check("drain_left", 64'(exp_q.size() + st_q.size()), 64'(0));
  endtask

  // Monitor: pops the scoreboard on every output transfer and store pulse.
  initial begin
    logic [OUT_W:0] e;
    forever begin
      @(negedge CP);
      if (!MR && bus.Send_out && bus.Ack_in) begin
        if (exp_q.size() == 0) fail_evt("unexpected_output");
        else begin
          e = exp_q.pop_front();
          check("pkt_out", 64'({bus.PACKET_OUT, bus.LOAD_FLG}), 64'(e));
        end
      end
      if (!MR && bus.WRITE_EN) begin
        if (st_q.size() == 0) fail_evt("unexpected_store");
        else check("store_data", 64'(bus.WRITE_DATA), 64'(st_q.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.PACKET_IN = '0;
    bus.Send_in   = 1'b0;
    bus.DEL       = 1'b0;
    bus.Ack_in    = 1'b0;
    MR            = 1'b1;
    m_c           = 1'b0;
    repeat (2) @(negedge CP);
    check("rst_ack_out",    64'(bus.Ack_out), 64'(1));
    check("rst_send_out",   64'(bus.Send_out), 64'(0));
    check("rst_write_en",   64'(bus.WRITE_EN), 64'(0));
    check("rst_load_flg",   64'(bus.LOAD_FLG), 64'(0));
    check("rst_write_data", 64'(bus.WRITE_DATA), 64'(0));
    check("rst_packet_out", 64'(bus.PACKET_OUT), 64'(0));
    @(posedge CP); #1;
    MR = 1'b0;
    bus.Ack_in = 1'b1;

    // Carry chain and single-cycle latency.
    send(22'h00001, OP_ADD, 2'd1, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    @(negedge CP); check("add_lat_n",  64'(bus.Send_out), 64'(0));
    @(negedge CP); check("add_lat_n1", 64'(bus.Send_out), 64'(1));
    @(posedge CP); #1;
    send(22'h00002, OP_ADDC, 2'd2, 16'h0000, 16'h0000, 1'b0, 1'b0);
    drain(40);

    // MUL result and latency.
    send(22'h00003, OP_MUL, 2'd3, 16'h0123, 16'h0010, 1'b0, 1'b0);
    for (int k = 0; k < DATA_W + 2; k++) begin
      @(negedge CP); check("mul_busy", 64'({bus.Send_out, bus.Ack_out}), 64'(0));
    end
    @(negedge CP); check("mul_done", 64'({bus.Send_out, bus.Ack_out}), 64'(3));
    drain(40);

    // Backpressure: DEPTH queued plus one held.
    bus.Ack_in = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++)
      send(HDR_W'(i + 16), OP_ADD, 2'(i), DATA_W'(i * 3), DATA_W'(100), 1'b0, 1'b0);
    repeat (3) begin
      @(negedge CP);
      check("full_ack_out",  64'(bus.Ack_out), 64'(0));
      check("full_send_out", 64'(bus.Send_out), 64'(1));
    end
    @(posedge CP); #1;
    drain(60);

    // DEL drops the ADD; STORE pulses the write port without pushing.
    send(22'h00030, OP_ADD, 2'd0, 16'h0001, 16'h0002, 1'b1, 1'b0);
    send(22'h00031, OP_STORE, 2'd1, 16'h7777, 16'hBEEF, 1'b0, 1'b0);
    @(negedge CP); check("st_we_n", 64'(bus.WRITE_EN), 64'(0));
    @(negedge CP);
    check("st_we_n1",  64'(bus.WRITE_EN), 64'(1));
    check("st_wdata",  64'(bus.WRITE_DATA), 64'(16'hBEEF));
    check("st_nopush", 64'(bus.Send_out), 64'(0));
    @(negedge CP);
    check("st_we_n2",   64'(bus.WRITE_EN), 64'(0));
    check("st_nopush2", 64'(bus.Send_out), 64'(0));
    @(posedge CP); #1;
    drain(20);

    // LOAD held behind a full FIFO; one-edge pop does not let it in on that edge.
    bus.Ack_in = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      send(HDR_W'(i + 64), OP_XOR, 2'(i), DATA_W'($urandom), DATA_W'($urandom), 1'b0, 1'b0);
    send(22'h00050, OP_LOAD, 2'd2, 16'h1234, 16'h5555, 1'b0, 1'b0);
    @(negedge CP); check("ld_stall", 64'(bus.Ack_out), 64'(0));
    @(posedge CP); #1 bus.Ack_in = 1'b1;
    @(posedge CP); #1 bus.Ack_in = 1'b0;
    @(negedge CP); check("ld_nopush_same_edge", 64'(bus.Ack_out), 64'(1));
    repeat (3) @(posedge CP);
    #1;
    drain(60);

    // Reset in the middle of a MUL, with carry previously set.
    send(22'h00060, OP_ADD, 2'd0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    drain(20);
    send(22'h00061, OP_MUL, 2'd1, 16'h00FF, 16'h0101, 1'b0, 1'b0);
    repeat (5) @(posedge CP);
    #1 MR = 1'b1;
    #1 check("mid_mul_rst", 64'({bus.Send_out, bus.Ack_out, bus.WRITE_EN}), 64'(3'b010));
    exp_q.delete();
    st_q.delete();
    m_c = 1'b0;
    @(posedge CP); #1 MR = 1'b0;
    for (int k = 0; k < DATA_W + 4; k++) begin
      @(negedge CP); check("no_late_push", 64'(bus.Send_out), 64'(0));
    end
    @(posedge CP); #1;
    send(22'h00062, OP_ADDC, 2'd2, 16'h0000, 16'h0000, 1'b0, 1'b0);
    drain(20);

    // Random traffic with random backpressure.
    for (int n = 0; n < 250; n++) begin
      int k;
      logic [5:0] op;
      k  = $urandom_range(0, 12);
      op = (k == 12) ? 6'd63 : 6'(k);
      bus.Ack_in = ($urandom_range(0, 3) != 0);
      send(HDR_W'($urandom), op, 2'($urandom), DATA_W'($urandom), DATA_W'($urandom),
           ($urandom_range(0, 9) == 0), 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge CP); #1;
      end
    end
    drain(400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
